uart_word_loader: RTL and testbench
===================================

# uart_word_loader

Serial front end of the board-level program/data loader: receives 8N1 UART bytes on `rx`, packs every four bytes little-endian into a 32-bit word, and presents each word with its byte address to the downstream register/memory writer. Drives that writer's `data_out` / `addr_out` / `done` inputs directly. One write-enable pulse is issued per assembled word. `done` is raised once a configured number of words has been loaded.

## Interface

**Parameters**
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD`, default 115_200: line rate; `CLKS_PER_BIT = CLK_FREQ / BAUD` (integer divide, must be ≥ 4).
- `WORD_COUNT`, default 16_384: number of words to load before `done`; must be ≥ 1.

**Ports**
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: UART serial input, idle high, asynchronous to `clk`.
- `data_out` output 32: last assembled word.
- `addr_out` output 32: byte address of `data_out` (word index × 4).
- `we` output 1: one-cycle pulse; `data_out` and `addr_out` are valid for a new word in this cycle.
- `done` output 1: sticky; high once `WORD_COUNT` words have been written.
- `frame_err` output 1: sticky; high once any stop bit sampled low.

## Operation

- **Input synchronizer:** `rx` passes through a 2-flop synchronizer; the synchronizer resets to 1. All decisions use the synchronized value `rx_s`.
- **FSM states:** IDLE, START, DATA, STOP, FINISHED.
- **IDLE:** on `rx_s == 0`, clear the bit timer and go to START.
- **START:** wait `CLKS_PER_BIT/2` cycles.
  - If `rx_s == 1`, treat it as a glitch: return to IDLE with no byte.
  - Otherwise go to DATA with bit index 0.
- **DATA:** every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, sample `rx_s`.
  - If 1: byte accepted.
  - If 0: byte discarded, `frame_err` set, byte counter unchanged.
  - Either way, return to IDLE. No wait for line idle; a low line restarts START next cycle.
- **Byte packing:** accepted byte `k` (0..3) is written to word buffer bits `[8k+7:8k]`.
  - On `k == 3`, the next cycle loads `data_out` with the full word and `addr_out` with `word_idx << 2`, pulses `we`, increments `word_idx`, and resets `k` to 0.
- **Completion:** when the word written is number `WORD_COUNT` (that is, `word_idx == WORD_COUNT-1` at write), `done` rises in the same cycle as that `we`. The FSM then enters FINISHED.
- **FINISHED:** `rx` is ignored until reset.
- **Output hold:** `data_out` and `addr_out` hold their values between pulses. Downstream may sample them at any time.
- **Arithmetic:** `word_idx` is 30 bits wide. `addr_out[1:0]` is always 0. The address never wraps for legal `WORD_COUNT`.

## Timing

- **Reset values:** `data_out = 0`, `addr_out = 0`, `we = 0`, `done = 0`, `frame_err = 0`. FSM in IDLE, byte counter 0, `word_idx` 0, word buffer 0.
- **Reset mid-operation:** asserting `rst_n` low at any point, including mid-byte or mid-word, discards partial bytes and words immediately and asynchronously.
- **Input latency:** 2 cycles from `rx` pin to `rx_s`.
- **Start check:** the start bit is checked `CLKS_PER_BIT/2` cycles after the `rx_s` falling edge.
- **Data sampling:** data bit `n` is sampled at `CLKS_PER_BIT/2 + (n+1)·CLKS_PER_BIT` cycles after that edge. The stop bit is sampled at `+9·CLKS_PER_BIT`.
- **Write latency:** `we` asserts exactly 1 cycle after the stop-bit sample of the 4th accepted byte. `we` lasts 1 cycle.
- **Back-to-back characters:** a new start bit may begin the cycle after the stop sample. `we` does not block reception.
- **Simultaneous events:** a start edge in the same cycle as `we` is accepted normally. A framing error on byte 3 produces no `we`, and the word remains pending at `k = 3`.

## Test plan

Sim parameters: `CLK_FREQ=16`, `BAUD=1` (`CLKS_PER_BIT=16`), `WORD_COUNT=2`.

1. **Reset:** hold `rst_n=0` with `rx` toggling → all outputs 0, no `we`. Release with `rx=1` → outputs stay 0.
2. **First word:** send 0x78, 0x56, 0x34, 0x12 → single `we` pulse 1 cycle after the 4th stop sample; `data_out=32'h12345678`, `addr_out=0`, `done=0`.
3. **Glitch rejection:** drive `rx` low for 3 cycles, then high → no byte accepted, no `we`. The next good word is still assembled from 4 fresh bytes.
4. **Framing error:** send 0xAA with stop bit 0 → `frame_err=1`, byte dropped. Then send 0xEF, 0xBE, 0xAD, 0xDE → `we` with `data_out=32'hDEADBEEF`, `addr_out=4`, and `done=1` in the same cycle.
5. **After done:** send 4 more bytes → no `we`; `data_out`, `addr_out`, `done` and `frame_err` unchanged.
6. **Reset mid-word:** after 2 bytes of a word, pulse `rst_n` low mid-byte → all outputs 0. Then 4 new bytes 0x01, 0x02, 0x03, 0x04 → `data_out=32'h04030201`, `addr_out=0`.

Source files
------------

// File: rtl/uart_word_loader.sv
// 8N1 UART receiver that packs four bytes little-endian into 32-bit words and
// issues one write pulse per word with its byte address, until WORD_COUNT words.
module uart_word_loader #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned WORD_COUNT = 16_384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [31:0] data_out,
  output logic [31:0] addr_out,
  output logic        we,
  output logic        done,
  output logic        frame_err
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned TW   = $clog2(CPB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_FINISHED
  } state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [TW-1:0] timer_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [1:0]    byte_k_q;
  logic [31:0]   word_q;
  logic [29:0]   word_idx_q;
  logic          wr_pend_q;
  logic          last_word_c;

  assign rx_s        = sync_q[1];
  assign last_word_c = (word_idx_q == 30'(WORD_COUNT - 1));

  // Two-flop synchronizer, idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_k_q   <= '0;
      word_q     <= '0;
      word_idx_q <= '0;
      wr_pend_q  <= 1'b0;
      data_out   <= '0;
      addr_out   <= '0;
      we         <= 1'b0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      we <= 1'b0;

      // Word write runs alongside reception so a new start bit is never blocked
      if (wr_pend_q) begin
        wr_pend_q  <= 1'b0;
        we         <= 1'b1;
        data_out   <= word_q;
        addr_out   <= {word_idx_q, 2'b00};
        word_idx_q <= word_idx_q + 30'd1;
        if (last_word_c) done <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            timer_q <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_q == TW'(HALF - 1)) begin
            timer_q <= '0;
            if (rx_s) begin
              state_q <= S_IDLE;
            end else begin
              bit_idx_q <= '0;
              state_q   <= S_DATA;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_DATA: begin
          if (timer_q == TW'(CPB - 1)) begin
            timer_q <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) state_q <= S_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_STOP: begin
          if (timer_q == TW'(CPB - 1)) begin
            timer_q <= '0;
            state_q <= S_IDLE;
            if (rx_s) begin
              word_q[{byte_k_q, 3'b000} +: 8] <= shift_q;
              byte_k_q <= byte_k_q + 2'd1;
              if (byte_k_q == 2'd3) wr_pend_q <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_FINISHED: ;
        default: state_q <= S_IDLE;
      endcase

      // Final word overrides whatever the receiver was about to do
      if (wr_pend_q && last_word_c) state_q <= S_FINISHED;
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench for uart_word_loader: bit-level UART driver, byte/word reference model
// and a write monitor that logs every we pulse with its cycle number.
module tb_uart_word_loader;

  localparam int unsigned CF  = 16;
  localparam int unsigned BD  = 1;
  localparam int unsigned WC  = 2;
  localparam int unsigned CPB = CF / BD;
  // rx driven at a negedge: sync (3 posedges to IDLE decision) + half bit + 9 bits + write cycle
  localparam int unsigned LAT = 3 + CPB / 2 + 9 * CPB + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        dn;
    logic [31:0] cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic [31:0] data_out;
  logic [31:0] addr_out;
  logic        we;
  logic        done;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  wr_t exp_q[$];
  wr_t obs_q[$];

  logic [7:0]  m_bytes[$];
  int          m_idx;
  bit          m_done;
  bit          m_ferr;
  logic [31:0] m_data;
  logic [31:0] m_addr;

  uart_word_loader #(.CLK_FREQ(CF), .BAUD(BD), .WORD_COUNT(WC)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_out(data_out), .addr_out(addr_out),
    .we(we), .done(done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (we === 1'b1) obs_q.push_back('{data_out, addr_out, done, 32'(cyc)});

  function automatic void model_reset();
    m_bytes.delete();
    exp_q.delete();
    m_idx  = 0;
    m_done = 0;
    m_ferr = 0;
    m_data = '0;
    m_addr = '0;
  endfunction

  // Drives one full 8N1 character and updates the reference model
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    int start;
    logic [31:0] w;
    @(negedge clk);
    start = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
    if (!m_done) begin
      if (!stop_ok) begin
        m_ferr = 1;
      end else begin
        m_bytes.push_back(b);
        if (m_bytes.size() == 4) begin
          w      = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          m_data = w;
          m_addr = 32'(m_idx * 4);
          m_done = (m_idx == int'(WC) - 1);
          exp_q.push_back('{w, m_addr, m_done, 32'(start + int'(LAT))});
          m_idx++;
          m_bytes.delete();
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rx = 1'(i % 3 == 0);
    end
    checks++;
    if ({data_out, addr_out, we, done, frame_err} !== 67'd0) begin
      failures++;
      $display("FAIL reset_hold: data=%h addr=%h we=%b done=%b ferr=%b, want all 0",
               data_out, addr_out, we, done, frame_err);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_hold_we: %0d we pulses, want 0", obs_q.size());
    end
    rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if ({data_out, addr_out, we, done, frame_err} !== 67'd0) begin
      failures++;
      $display("FAIL reset_release: data=%h addr=%h we=%b done=%b ferr=%b, want all 0",
               data_out, addr_out, we, done, frame_err);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL reset_release_we: %0d we pulses, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_first_word();
    logic [7:0] bytes[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    wr_t o, e;
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL first_word_count: %0d we pulses, want %0d", obs_q.size(), exp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e || e.data !== 32'h12345678 || e.addr !== 32'd0) begin
        failures++;
        $display("FAIL first_word: got data=%h addr=%h done=%b cyc=%0d, want data=%h addr=%h done=%b cyc=%0d",
                 o.data, o.addr, o.dn, o.cyc, e.data, e.addr, e.dn, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
    checks++;
    if (we !== 1'b0 || done !== 1'b0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL first_word_flags: we=%b done=%b ferr=%b, want 0 0 0", we, done, frame_err);
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL glitch: we pulses=%0d ferr=%b, want 0 0", obs_q.size(), frame_err);
    end
    checks++;
    if (data_out !== m_data || addr_out !== m_addr) begin
      failures++;
      $display("FAIL glitch_hold: data=%h addr=%h, want %h %h", data_out, addr_out, m_data, m_addr);
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] bytes[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wr_t o, e;
    send_byte(8'hAA, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || obs_q.size() != 0) begin
      failures++;
      $display("FAIL frame_err_set: ferr=%b we pulses=%0d, want 1 0", frame_err, obs_q.size());
    end
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL second_word_count: %0d we pulses, want %0d", obs_q.size(), exp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e || e.data !== 32'hDEADBEEF || e.addr !== 32'd4 || e.dn !== 1'b1) begin
        failures++;
        $display("FAIL second_word: got data=%h addr=%h done=%b cyc=%0d, want data=%h addr=%h done=%b cyc=%0d",
                 o.data, o.addr, o.dn, o.cyc, e.data, e.addr, e.dn, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_after_done();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'(i != 2));
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL after_done_we: %0d we pulses, want 0", obs_q.size());
    end
    checks++;
    if (data_out !== m_data || addr_out !== m_addr || done !== m_done || frame_err !== m_ferr) begin
      failures++;
      $display("FAIL after_done_hold: data=%h addr=%h done=%b ferr=%b, want %h %h %b %b",
               data_out, addr_out, done, frame_err, m_data, m_addr, m_done, m_ferr);
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] bytes[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    wr_t o, e;
    do_reset();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CPB + 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, addr_out, we, done, frame_err} !== 67'd0) begin
      failures++;
      $display("FAIL reset_mid_word: data=%h addr=%h we=%b done=%b ferr=%b, want all 0",
               data_out, addr_out, we, done, frame_err);
    end
    model_reset();
    obs_q.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL post_reset_count: %0d we pulses, want %0d", obs_q.size(), exp_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e || e.data !== 32'h04030201 || e.addr !== 32'd0) begin
        failures++;
        $display("FAIL post_reset_word: got data=%h addr=%h done=%b cyc=%0d, want data=%h addr=%h done=%b cyc=%0d",
                 o.data, o.addr, o.dn, o.cyc, e.data, e.addr, e.dn, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    wr_t o, e;
    for (int run = 0; run < 3; run++) begin
      do_reset();
      for (int n = 0; n < 30 && !m_done; n++) send_byte(8'($urandom), 1'($urandom_range(0, 4) != 0));
      send_byte(8'($urandom), 1'b0);
      repeat (4) @(negedge clk);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        failures++;
        $display("FAIL random_count run%0d: %0d we pulses, want %0d", run, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random_word run%0d: got data=%h addr=%h done=%b cyc=%0d, want data=%h addr=%h done=%b cyc=%0d",
                   run, o.data, o.addr, o.dn, o.cyc, e.data, e.addr, e.dn, e.cyc);
        end
      end
      checks++;
      if (data_out !== m_data || addr_out !== m_addr || done !== m_done || frame_err !== m_ferr) begin
        failures++;
        $display("FAIL random_final run%0d: data=%h addr=%h done=%b ferr=%b, want %h %h %b %b",
                 run, data_out, addr_out, done, frame_err, m_data, m_addr, m_done, m_ferr);
      end
      obs_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_glitch();
    test_frame_err();
    test_after_done();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
